// File: rtl/day7_piso_serializer.sv
// Parallel-in/serial-out serializer: takes a word over valid/ready and shifts it out
// one bit per enabled clock, with back-to-back reload on the last bit.
module day7_piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load_valid,
    output logic             o_load_ready,
    input  logic [WIDTH-1:0] i_data_in,
    input  logic             i_shift_en,
    output logic             o_serial_out,
    output logic             o_serial_valid,
    output logic             o_busy,
    output logic             o_done
);

    // state   | meaning
    // S_IDLE  | no word on the line, ready for a new one
    // S_SHIFT | shifting a word out, one bit per enabled edge
    typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} state_t;

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_done;
    logic             w_last;
    logic             w_accept;
    logic [WIDTH-1:0] w_shifted;

    // Last-bit edge frees the slot so a waiting word can follow with no gap.
    assign w_last       = (r_state == S_SHIFT) && (r_cnt == LAST_CNT) && i_shift_en;
    assign o_load_ready = (r_state == S_IDLE) || w_last;
    assign w_accept     = i_load_valid && o_load_ready;
    assign w_shifted    = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0} : {1'b0, r_shreg[WIDTH-1:1]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_last && !w_accept) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy         = (r_state == S_SHIFT);
        o_serial_valid = (r_state == S_SHIFT);
        o_serial_out   = 1'b0;
        if (r_state == S_SHIFT) begin
            o_serial_out = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
        end
        o_done = r_done;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shreg <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_shreg <= i_data_in;
                r_cnt   <= '0;
            end else if (w_last) begin
                r_shreg <= '0;
                r_cnt   <= '0;
            end else if ((r_state == S_SHIFT) && i_shift_en) begin
                r_shreg <= w_shifted;
                r_cnt   <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_day7_piso_serializer.sv
// Directed bench for day7_piso_serializer: MSB-first and LSB-first instances share stimulus,
// plus a loopback against a small behavioural SIPO receiver.
module tb_day7_piso_serializer;

    logic       clk;
    logic       rst_n;
    logic       load_valid;
    logic [3:0] data_in;
    logic       shift_en;

    logic m_ready, m_sout, m_svalid, m_busy, m_done;
    logic l_ready, l_sout, l_svalid, l_busy, l_done;

    int checks   = 0;
    int failures = 0;

    day7_piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(load_valid), .o_load_ready(m_ready),
        .i_data_in(data_in), .i_shift_en(shift_en), .o_serial_out(m_sout),
        .o_serial_valid(m_svalid), .o_busy(m_busy), .o_done(m_done)
    );

    day7_piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
        .i_clk(clk), .i_rst_n(rst_n), .i_load_valid(load_valid), .o_load_ready(l_ready),
        .i_data_in(data_in), .i_shift_en(shift_en), .o_serial_out(l_sout),
        .o_serial_valid(l_svalid), .o_busy(l_busy), .o_done(l_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_sout"},  {7'd0, m_sout},   8'd0);
        check({tag, "_valid"}, {7'd0, m_svalid}, 8'd0);
        check({tag, "_busy"},  {7'd0, m_busy},   8'd0);
        check({tag, "_ready"}, {7'd0, m_ready},  8'd1);
    endtask

    logic [3:0] exp_msb;
    logic [3:0] exp_lsb;
    logic [6:0] stall_pat;
    logic [5:0] stall_exp;
    logic [7:0] b2b_exp;
    logic [3:0] word;
    logic [3:0] rx;
    int         rx_bits;
    int         budget;

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        data_in    = 4'h0;
        shift_en   = 1'b0;
        #2;
        check_idle("rst_init");
        check("rst_init_done", {7'd0, m_done}, 8'd0);
        tick();
        #3 rst_n = 1'b1;
        tick();

        // MSB-first 1011 -> 1,0,1,1 and LSB-first 1011 -> 1,1,0,1 on the same cycles
        exp_msb    = 4'b1011;
        exp_lsb    = 4'b1011;
        load_valid = 1'b1;
        data_in    = 4'b1011;
        shift_en   = 1'b1;
        tick();
        load_valid = 1'b0;
        data_in    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("msb_bit%0d", i), {7'd0, m_sout}, {7'd0, exp_msb[3-i]});
            check($sformatf("lsb_bit%0d", i), {7'd0, l_sout}, {7'd0, exp_lsb[i]});
            check($sformatf("msb_valid%0d", i), {7'd0, m_svalid}, 8'd1);
            check($sformatf("msb_done%0d", i), {7'd0, m_done}, 8'd0);
            check($sformatf("msb_ready%0d", i), {7'd0, m_ready}, (i == 3) ? 8'd1 : 8'd0);
            tick();
        end
        check("msb_done_pulse", {7'd0, m_done}, 8'd1);
        check("lsb_done_pulse", {7'd0, l_done}, 8'd1);
        check_idle("after_word");
        tick();
        check("msb_done_clear", {7'd0, m_done}, 8'd0);

        // Stall: 4'hC with shift_en 1,0,0,1,0,1,1 on the edges after accept
        stall_pat  = 7'b1101001;
        stall_exp  = 6'b000111;
        load_valid = 1'b1;
        data_in    = 4'hC;
        tick();
        load_valid = 1'b0;
        check("stall_bit0", {7'd0, m_sout}, 8'd1);
        for (int i = 0; i < 7; i++) begin
            shift_en = stall_pat[i];
            tick();
            if (i < 6) begin
                check($sformatf("stall_sout%0d", i), {7'd0, m_sout}, {7'd0, stall_exp[i]});
                check($sformatf("stall_valid%0d", i), {7'd0, m_svalid}, 8'd1);
                check($sformatf("stall_done%0d", i), {7'd0, m_done}, 8'd0);
            end
        end
        check("stall_done", {7'd0, m_done}, 8'd1);
        check("stall_idle", {7'd0, m_svalid}, 8'd0);
        tick();

        // Back-to-back: 4'hA then 4'h5 with load_valid held high
        b2b_exp    = 8'b1010_0101;
        shift_en   = 1'b1;
        load_valid = 1'b1;
        data_in    = 4'hA;
        tick();
        data_in    = 4'h5;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("b2b_bit%0d", i), {7'd0, m_sout}, {7'd0, b2b_exp[7-i]});
            check($sformatf("b2b_valid%0d", i), {7'd0, m_svalid}, 8'd1);
            check($sformatf("b2b_done%0d", i), {7'd0, m_done}, (i == 4) ? 8'd1 : 8'd0);
            if (i == 4) load_valid = 1'b0;
            tick();
        end
        check("b2b_done_end", {7'd0, m_done}, 8'd1);
        check("b2b_idle", {7'd0, m_svalid}, 8'd0);
        tick();

        // Mid-word reset on 4'hF after two bits, then a clean 4'h3
        load_valid = 1'b1;
        data_in    = 4'hF;
        tick();
        load_valid = 1'b0;
        tick();
        check("abort_pre_bit", {7'd0, m_sout}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle("abort_rst");
        check("abort_rst_done", {7'd0, m_done}, 8'd0);
        tick();
        check("abort_rst_done2", {7'd0, m_done}, 8'd0);
        #2 rst_n = 1'b1;
        tick();
        check("abort_release_done", {7'd0, m_done}, 8'd0);
        check_idle("abort_release");
        load_valid = 1'b1;
        data_in    = 4'h3;
        tick();
        load_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post_rst_bit%0d", i), {7'd0, m_sout}, (i < 2) ? 8'd0 : 8'd1);
            tick();
        end
        check("post_rst_done", {7'd0, m_done}, 8'd1);
        tick();

        // Loopback into a behavioural MSB-first SIPO with random bit-rate gaps
        for (int w = 0; w < 50; w++) begin
            word       = 4'($urandom_range(0, 15));
            load_valid = 1'b1;
            data_in    = word;
            tick();
            load_valid = 1'b0;
            data_in    = ~word;
            rx         = 4'h0;
            rx_bits    = 0;
            budget     = 0;
            while (!m_done && budget < 40) begin
                shift_en = ($urandom_range(0, 3) != 0);
                if (m_svalid && shift_en) begin
                    rx = {rx[2:0], m_sout};
                    rx_bits++;
                end
                tick();
                budget++;
            end
            check($sformatf("loop_timeout%0d", w), {7'd0, m_done}, 8'd1);
            check($sformatf("loop_bits%0d", w), 8'(rx_bits), 8'd4);
            check($sformatf("loop_word%0d", w), {4'd0, rx}, {4'd0, word});
            shift_en = 1'b1;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
